// File: rtl/ac_pkg.sv
// Shared AC definitions: FSM encoding, default timing and drive payload.
package ac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HEAT = 2'd1,
        ST_COOL = 2'd2,
        ST_DEAD = 2'd3
    } state_t;

    localparam int unsigned MIN_ON_DEF    = 8;
    localparam int unsigned DEAD_TIME_DEF = 4;

    typedef struct packed {
        logic heater_on;
        logic cooler_on;
        logic conflict;
    } drive_t;

    // Counter width able to hold the larger of the two limits without wrapping.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/ac_actuator_if.sv
// Request/drive bundle between the AC controller (master) and the actuator (slave).
interface ac_actuator_if;
    import ac_pkg::*;

    logic   heating_req;
    logic   cooling_req;
    logic   heater_on;
    logic   cooler_on;
    logic   conflict;
    state_t state;

    modport master (
        output heating_req, cooling_req,
        input  heater_on, cooler_on, conflict, state
    );

    modport slave (
        input  heating_req, cooling_req,
        output heater_on, cooler_on, conflict, state
    );
endinterface

// File: rtl/ac_timer.sv
// Loadable saturating up-counter with clear; done_c flags the last cycle before the limit.
module ac_timer #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic [W-1:0] limit,
    output logic         done_c
);
    logic [W-1:0] cnt;

    // Clear wins over load, load wins over count; count stops at limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt < limit)) begin
            cnt <= cnt + W'(1);
        end
    end

    // Limit reached at the coming edge.
    assign done_c = (cnt >= (limit - W'(1)));
endmodule

// File: rtl/ac_actuator.sv
// Heater/cooler drive with minimum on-time, dead time and request conflict flag.
module ac_actuator
    import ac_pkg::*;
#(
    parameter int unsigned MIN_ON    = MIN_ON_DEF,
    parameter int unsigned DEAD_TIME = DEAD_TIME_DEF
) (
    input  logic         clk,
    input  logic         rst,
    ac_actuator_if.slave bus
);
    localparam int unsigned      CNT_W      = cnt_width(MIN_ON, DEAD_TIME);
    localparam logic [CNT_W-1:0] ON_LIMIT   = CNT_W'(MIN_ON);
    localparam logic [CNT_W-1:0] DEAD_LIMIT = CNT_W'(DEAD_TIME);

    state_t state_q;
    state_t state_next;
    drive_t drive_q;
    drive_t drive_next;

    logic heat_only;
    logic cool_only;
    logic both_req;
    logic entering;
    logic on_en;
    logic dead_en;
    logic on_done_c;
    logic dead_done_c;

    assign heat_only = bus.heating_req & ~bus.cooling_req;
    assign cool_only = bus.cooling_req & ~bus.heating_req;
    assign both_req  = bus.heating_req & bus.cooling_req;
    assign entering  = (state_next != state_q);
    assign on_en     = (state_q == ST_HEAT) || (state_q == ST_COOL);
    assign dead_en   = (state_q == ST_DEAD);

    ac_timer #(.W(CNT_W)) u_on_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (entering),
        .en       (on_en),
        .load     (1'b0),
        .load_val ('0),
        .limit    (ON_LIMIT),
        .done_c   (on_done_c)
    );

    ac_timer #(.W(CNT_W)) u_dead_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (entering),
        .en       (dead_en),
        .load     (1'b0),
        .load_val ('0),
        .limit    (DEAD_LIMIT),
        .done_c   (dead_done_c)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    // Next state: every switch-off passes through DEAD, never HEAT<->COOL directly.
    always_comb begin
        state_next = state_q;
        case (state_q)
            ST_IDLE: begin
                if (heat_only) begin
                    state_next = ST_HEAT;
                end else if (cool_only) begin
                    state_next = ST_COOL;
                end
            end
            ST_HEAT: begin
                if (!heat_only && on_done_c) begin
                    state_next = ST_DEAD;
                end
            end
            ST_COOL: begin
                if (!cool_only && on_done_c) begin
                    state_next = ST_DEAD;
                end
            end
            ST_DEAD: begin
                if (dead_done_c) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Drive values follow the state being entered so outputs switch on the same edge.
    always_comb begin
        drive_next           = '0;
        drive_next.heater_on = (state_next == ST_HEAT);
        drive_next.cooler_on = (state_next == ST_COOL);
        drive_next.conflict  = both_req;
    end

    // Output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            drive_q <= '0;
        end else begin
            drive_q <= drive_next;
        end
    end

    assign bus.heater_on = drive_q.heater_on;
    assign bus.cooler_on = drive_q.cooler_on;
    assign bus.conflict  = drive_q.conflict;
    assign bus.state     = state_q;
endmodule

// File: doc/ac_actuator.md
AC_ACTUATOR -- requirements
Module: ac_actuator

Interface
REQ-001 Parameter MIN_ON, default 8: minimum cycles an actuator output stays asserted once switched on (range 1-255).
REQ-002 Parameter DEAD_TIME, default 4: cycles both outputs are held low between any actuator switch-off and the next switch-on (range 1-255).
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  system clock; all state changes on the rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 heating_req  input  1  heat demand from the upstream AC controller's heating output.
REQ-007 cooling_req  input  1  cool demand from the upstream AC controller's cooling output.
REQ-008 heater_on  output  1  registered heater drive.
REQ-009 cooler_on  output  1  registered cooler drive.
REQ-010 conflict  output  1  registered; high for one cycle per cycle in which both requests were sampled high.
REQ-011 state  output  2  current FSM state: IDLE=0, HEAT=1, COOL=2, DEAD=3.

Function
REQ-012 The FSM SHALL have four states: IDLE, HEAT, COOL, DEAD.
REQ-013 All outputs SHALL be registered; no combinational input-to-output path.
REQ-014 In IDLE, with heating_req=1 and cooling_req=0 sampled at edge N, the FSM enters HEAT and heater_on=1 from edge N (1-cycle latency).
REQ-015 In IDLE, with cooling_req=1 and heating_req=0, the FSM enters COOL and cooler_on=1 on the same edge.
REQ-016 In IDLE, with both requests high, the FSM stays in IDLE, both outputs stay 0, and conflict=1.
REQ-017 On entry to HEAT or COOL, an on-counter SHALL clear to 0, then increment each cycle and saturate at MIN_ON.
REQ-018 HEAT SHALL persist while heating_req=1 and cooling_req=0.
REQ-019 HEAT SHALL exit to DEAD on the first edge where the request is invalid (heating_req=0, or both high) and the on-counter is at least MIN_ON-1.
REQ-020 Consequence of REQ-019: heater_on is high for at least MIN_ON cycles.
REQ-021 COOL SHALL mirror REQ-018 and REQ-019 with the requests swapped.
REQ-022 In DEAD, both outputs SHALL be 0. A dead-counter counts DEAD_TIME cycles, then the FSM returns to IDLE; requests are ignored during DEAD.
REQ-023 heater_on and cooler_on SHALL never be high in the same cycle, and no direct HEAT<->COOL transition SHALL exist.
REQ-024 conflict SHALL assert in any state in which both requests are sampled high, including HEAT and COOL.
REQ-025 Counter widths SHALL be $clog2(max(MIN_ON, DEAD_TIME)+1); counters SHALL never wrap.

Reset
REQ-026 When rst=1 at a rising edge, state=IDLE, heater_on=0, cooler_on=0, conflict=0, and both counters=0, effective on that edge.
REQ-027 Reset SHALL override MIN_ON and DEAD_TIME: if asserted mid-HEAT or mid-COOL, the outputs drop on that edge.
REQ-028 After rst deasserts, the first request SHALL be evaluated from IDLE with no dead time.

Structure
REQ-029 State encodings and default MIN_ON/DEAD_TIME values SHALL live in shared package ac_pkg, for use by the AC controller and the bench.
REQ-030 The on-counter and dead-counter SHALL each be an instance of sub-module ac_timer, a loadable saturating up-counter with a clear input and a done flag.

Verification (MIN_ON=8, DEAD_TIME=4)
REQ-031 Reset: rst=1 for 3 cycles with heating_req=1 -> heater_on=0, cooler_on=0, state=0 throughout; heater_on=1 at the first edge after release.
REQ-032 Long heat: heating_req=1 for cycles 0-19 -> heater_on high for cycles 1-20 and low from 21; state=3 for 4 cycles, then 0.
REQ-033 Short pulse: heating_req=1 for 2 cycles -> heater_on high for exactly 8 cycles, then 4 DEAD cycles.
REQ-034 Swap: cooling_req rises in the cycle heating_req falls, after 10 cycles of heat -> cooler_on first goes high at least 5 edges after heater_on falls; the outputs are never both high.
REQ-035 Conflict: both requests high for 3 cycles from IDLE -> conflict=1 for 3 cycles, both outputs 0, state=0.
REQ-036 Mid-operation reset: rst pulsed at cycle 3 of COOL -> cooler_on=0 on that edge and state=0, with no DEAD phase.
